// File: rtl/wbus_pkg.sv
// Shared W-bus definitions: data/lane widths, responder FSM states and the window-hit helper.
package wbus_pkg;

  localparam int unsigned WBUS_DW   = 32;
  localparam int unsigned WBUS_SELW = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ACK,
    ST_DONE
  } wbus_state_e;

  // True when addr lies in the 4*2^addr_bits byte window that starts at base.
  function automatic logic wbus_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned addr_bits);
    logic [31:0] w_diff;
    w_diff = (addr ^ base) >> (addr_bits + 2);
    return (w_diff == '0);
  endfunction

endpackage

// File: rtl/wbus_mem_slave_if.sv
// W-bus signal bundle; names follow the initiator's view so nets connect by name.
interface wbus_mem_slave_if;
  import wbus_pkg::*;

  logic                 W_REQ;
  logic [31:0]          W_ADDR;
  logic                 W_WRITE;
  logic [WBUS_SELW-1:0] W_SEL;
  logic [WBUS_DW-1:0]   W_DATA_O;
  logic [WBUS_DW-1:0]   W_DATA_I;
  logic                 W_ACK;

  modport master (
    output W_REQ, W_ADDR, W_WRITE, W_SEL, W_DATA_O,
    input  W_DATA_I, W_ACK
  );

  modport slave (
    input  W_REQ, W_ADDR, W_WRITE, W_SEL, W_DATA_O,
    output W_DATA_I, W_ACK
  );

endinterface

// File: rtl/wbus_sram.sv
// Single-port word RAM with synchronous read and per-byte write enables; no bus logic.
module wbus_sram
  import wbus_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 i_clk,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic                 i_we,
  input  logic [WBUS_SELW-1:0] i_be,
  input  logic [WBUS_DW-1:0]   i_wdata,
  output logic [WBUS_DW-1:0]   o_rdata
);

  logic [WBUS_DW-1:0] r_mem [2**ADDR_BITS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int unsigned i = 0; i < WBUS_SELW; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/wbus_mem_slave.sv
// W-bus memory responder: window decode, wait-state FSM and registered ack/read-data,
// backed by a wbus_sram. Return data is zero except in the read ack cycle.
module wbus_mem_slave
  import wbus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic               W_CLK,
  input  logic               W_RSTN,
  wbus_mem_slave_if.slave    bus
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  wbus_state_e          r_state;
  logic [3:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_idx;
  logic                 r_write;
  logic [WBUS_SELW-1:0] r_sel;
  logic [WBUS_DW-1:0]   r_wdata;
  logic                 r_ack;
  logic [WBUS_DW-1:0]   r_rdata;

  logic                 w_hit;
  logic [ADDR_BITS-1:0] w_req_idx;
  logic [ADDR_BITS-1:0] w_ram_addr;
  logic                 w_ram_we;
  logic [WBUS_DW-1:0]   w_ram_rdata;

  assign w_hit     = wbus_hit(bus.W_ADDR, BASE_ADDR, ADDR_BITS);
  assign w_req_idx = bus.W_ADDR[ADDR_BITS+1:2];

  // In IDLE the RAM is addressed straight from the bus so a zero-wait read
  // already has its word on the RAM output during ACCESS.
  assign w_ram_addr = (r_state == ST_IDLE) ? w_req_idx : r_idx;
  assign w_ram_we   = (r_state == ST_ACCESS) && r_write;

  wbus_sram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_sram (
    .i_clk   (W_CLK),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_be    (r_sel),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge W_CLK or negedge W_RSTN) begin
    if (!W_RSTN) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_sel   <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.W_REQ && w_hit) begin
            r_idx   <= w_req_idx;
            r_write <= bus.W_WRITE;
            r_sel   <= bus.W_SEL;
            r_wdata <= bus.W_DATA_O;
            r_cnt   <= WS;
            r_state <= (WS == '0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          r_ack   <= 1'b1;
          r_rdata <= r_write ? '0 : w_ram_rdata;
          r_state <= ST_ACK;
        end
        ST_ACK:  r_state <= ST_DONE;
        ST_DONE: if (!bus.W_REQ) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.W_ACK    = r_ack;
  assign bus.W_DATA_I = r_rdata;

endmodule

// File: tb/tb_wbus_mem_slave.sv
// Bench: three responders (0, 1 and 15 wait states) share one W bus; checks latency,
// byte-lane writes, misses, held requests and reset against a word-array model.
module tb_wbus_mem_slave;

  localparam logic [31:0] B0  = 32'h2000_0000;
  localparam logic [31:0] B1  = 32'h0001_0000;
  localparam logic [31:0] B15 = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ack_bus;
  logic [31:0] data_bus;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [logic [31:0]];

  always #5 clk = ~clk;

  wbus_mem_slave_if b0 ();
  wbus_mem_slave_if b1 ();
  wbus_mem_slave_if b15 ();

  assign b0.W_REQ = req;   assign b0.W_ADDR = addr;   assign b0.W_WRITE = we;
  assign b0.W_SEL = sel;   assign b0.W_DATA_O = wdata;
  assign b1.W_REQ = req;   assign b1.W_ADDR = addr;   assign b1.W_WRITE = we;
  assign b1.W_SEL = sel;   assign b1.W_DATA_O = wdata;
  assign b15.W_REQ = req;  assign b15.W_ADDR = addr;  assign b15.W_WRITE = we;
  assign b15.W_SEL = sel;  assign b15.W_DATA_O = wdata;

  assign ack_bus  = b0.W_ACK | b1.W_ACK | b15.W_ACK;
  assign data_bus = b0.W_DATA_I | b1.W_DATA_I | b15.W_DATA_I;

  wbus_mem_slave #(.BASE_ADDR(B0), .ADDR_BITS(10), .WAIT_STATES(0))
    u_ws0 (.W_CLK(clk), .W_RSTN(rst_n), .bus(b0));
  wbus_mem_slave #(.BASE_ADDR(B1), .ADDR_BITS(10), .WAIT_STATES(1))
    u_ws1 (.W_CLK(clk), .W_RSTN(rst_n), .bus(b1));
  wbus_mem_slave #(.BASE_ADDR(B15), .ADDR_BITS(10), .WAIT_STATES(15))
    u_ws15 (.W_CLK(clk), .W_RSTN(rst_n), .bus(b15));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return mem_m.exists(w) ? mem_m[w] : 32'h0;
  endfunction

  task automatic m_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] v;
    v = m_rd(a);
    for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
    mem_m[{a[31:2], 2'b00}] = v;
  endtask

  function automatic int ws_of(input logic [31:0] a);
    if (a[31:28] == 4'h2) return 0;
    if (a[31:28] == 4'h3) return 15;
    return 1;
  endfunction

  // One complete transaction; ack must appear exactly ws+1 edges after the sampling edge.
  task automatic txn(input logic [31:0] a, input logic wr, input logic [3:0] s,
                     input logic [31:0] d);
    int ws;
    logic [31:0] rd;
    ws = ws_of(a);
    rd = '0;
    @(negedge clk);
    req = 1'b1; addr = a; we = wr; sel = s; wdata = d;
    for (int k = 0; k <= ws + 2; k++) begin
      @(posedge clk); #1;
      chk("ack_timing", 32'(ack_bus), 32'(k == ws + 1));
      if (k == ws + 1) rd = data_bus;
      else chk("data_idle", data_bus, 32'h0);
    end
    @(negedge clk);
    req = 1'b0;
    if (wr) m_wr(a, s, d);
    else chk("rdata", rd, m_rd(a));
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = '0; we = 1'b0; sel = '0; wdata = '0;
    #1;
    chk("rst_ack", 32'(ack_bus), 32'h0);
    chk("rst_data", data_bus, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    txn(B1 + 32'h10, 1'b0, 4'h0, 32'h0);
    chk("init_zero", m_rd(B1 + 32'h10), 32'h0);

    txn(B1 + 32'h4, 1'b1, 4'hF, 32'hDEAD_BEEF);
    txn(B1 + 32'h4, 1'b1, 4'b0001, 32'h0000_00AA);
    txn(B1 + 32'h4, 1'b0, 4'h0, 32'h0);
    chk("merge_model", m_rd(B1 + 32'h4), 32'hDEAD_BEAA);
    txn(B1 + 32'h4, 1'b1, 4'h0, 32'h1111_1111);
    txn(B1 + 32'h4, 1'b0, 4'h0, 32'h0);

    // Just past the top of the window: nobody answers.
    @(negedge clk);
    req = 1'b1; addr = B1 + 32'h1000; we = 1'b0; sel = 4'h0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("miss_ack", 32'(ack_bus), 32'h0);
      chk("miss_data", data_bus, 32'h0);
    end
    @(negedge clk); req = 1'b0;

    txn(B0 + 32'h20, 1'b1, 4'hF, 32'h0BAD_F00D);
    txn(B0 + 32'h20, 1'b0, 4'h0, 32'h0);
    txn(B15 + 32'h40, 1'b1, 4'hF, 32'hCAFE_F00D);
    txn(B15 + 32'h40, 1'b0, 4'h0, 32'h0);

    // Request held after ack: only one ack, then a fresh assertion starts again.
    @(negedge clk);
    req = 1'b1; addr = B1 + 32'h4; we = 1'b0; sel = 4'h0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      chk("held_ack", 32'(ack_bus), 32'(k == 2));
    end
    @(negedge clk); req = 1'b0;
    txn(B1 + 32'h4, 1'b0, 4'h0, 32'h0);

    for (int n = 0; n < 36; n++) begin
      logic [31:0] base, a;
      int inst;
      inst = int'($urandom_range(0, 2));
      base = (inst == 0) ? B0 : (inst == 1) ? B1 : B15;
      a = base + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
      txn(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
    end

    // Reset during WAIT of a write: the write must not land.
    @(negedge clk);
    req = 1'b1; addr = B15 + 32'h40; we = 1'b1; sel = 4'hF; wdata = 32'h1234_5678;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rstwait_ack", 32'(ack_bus), 32'h0);
    chk("rstwait_data", data_bus, 32'h0);
    @(negedge clk); req = 1'b0; rst_n = 1'b1;
    txn(B15 + 32'h40, 1'b0, 4'h0, 32'h0);

    // Reset in the read-ack cycle clears outputs immediately.
    txn(B1 + 32'h8, 1'b1, 4'hF, 32'h5A5A_A5A5);
    @(negedge clk);
    req = 1'b1; addr = B1 + 32'h8; we = 1'b0; sel = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("ackrd_ack", 32'(ack_bus), 32'h1);
    chk("ackrd_data", data_bus, m_rd(B1 + 32'h8));
    #2 rst_n = 1'b0;
    #1;
    chk("rstack_ack", 32'(ack_bus), 32'h0);
    chk("rstack_data", data_bus, 32'h0);
    @(negedge clk); req = 1'b0; rst_n = 1'b1;
    txn(B1 + 32'h8, 1'b0, 4'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
